sram_rr_arbiter: RTL and testbench

SRAM_RR_ARBITER -- requirements
Module: sram_rr_arbiter

---
 rtl/sram_rr_arbiter.sv | 135 +++++++++++++
 tb/tb_sram_rr_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_rr_arbiter.sv
// rtl/sram_rr_arbiter.sv - four-requester round-robin arbiter onto a dual-port SRAM macro
module sram_rr_arbiter #(
  parameter int ADDR_W = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          req_valid,
  output logic [3:0]          req_ready,
  input  logic [3:0]          req_we,
  input  logic [4*ADDR_W-1:0] req_addr,
  input  logic [127:0]        req_wdata,
  input  logic [15:0]         req_mask,
  output logic [3:0]          resp_valid,
  output logic [127:0]        resp_rdata,
  output logic [ADDR_W-1:0]   sram_a1,
  output logic [ADDR_W-1:0]   sram_a2,
  output logic                sram_csb1,
  output logic                sram_csb2,
  output logic                sram_web1,
  output logic                sram_web2,
  output logic                sram_oeb1,
  output logic                sram_oeb2,
  output logic [3:0]          sram_bytemask1,
  output logic [3:0]          sram_bytemask2,
  output logic [31:0]         sram_i1,
  output logic [31:0]         sram_i2,
  input  logic [31:0]         sram_o1,
  input  logic [31:0]         sram_o2
);

  logic [1:0] rr_ptr;
  logic [3:0] pend;
  logic [3:0] pend_port;  // 0 = port 1, 1 = port 2
  logic [3:0] pend_rd;

  logic       p1_hit, p2_hit;
  logic [1:0] p1_idx, p2_idx;
  logic [1:0] idx;
  logic       conflict;

  // Scan from rr_ptr: first valid takes port 1, next non-conflicting valid takes port 2
  always_comb begin
    p1_hit   = 1'b0;
    p1_idx   = 2'd0;
    p2_hit   = 1'b0;
    p2_idx   = 2'd0;
    idx      = 2'd0;
    conflict = 1'b0;
    if (!reset) begin
      for (int k = 0; k < 4; k++) begin
        idx = rr_ptr + 2'(k);
        conflict = (req_addr[32'(idx)*ADDR_W +: ADDR_W] == req_addr[32'(p1_idx)*ADDR_W +: ADDR_W])
                   && (req_we[idx] || req_we[p1_idx]);
        if (req_valid[idx]) begin
          if (!p1_hit) begin
            p1_hit = 1'b1;
            p1_idx = idx;
          end else if (!p2_hit && !conflict) begin
            p2_hit = 1'b1;
            p2_idx = idx;
          end
        end
      end
    end
  end

  // Grant vector is the set of requesters placed on a port this cycle
  always_comb begin
    req_ready = 4'd0;
    if (p1_hit) req_ready[p1_idx] = 1'b1;
    if (p2_hit) req_ready[p2_idx] = 1'b1;
  end

  // Drive the macro ports from the selected requests, idle values otherwise
  always_comb begin
    sram_csb1      = 1'b1;
    sram_web1      = 1'b1;
    sram_oeb1      = 1'b1;
    sram_a1        = '0;
    sram_bytemask1 = 4'd0;
    sram_i1        = 32'd0;
    sram_csb2      = 1'b1;
    sram_web2      = 1'b1;
    sram_oeb2      = 1'b1;
    sram_a2        = '0;
    sram_bytemask2 = 4'd0;
    sram_i2        = 32'd0;
    if (p1_hit) begin
      sram_csb1      = 1'b0;
      sram_web1      = ~req_we[p1_idx];
      sram_oeb1      = req_we[p1_idx];
      sram_a1        = req_addr[32'(p1_idx)*ADDR_W +: ADDR_W];
      sram_bytemask1 = req_mask[32'(p1_idx)*4 +: 4];
      sram_i1        = req_wdata[32'(p1_idx)*32 +: 32];
    end
    if (p2_hit) begin
      sram_csb2      = 1'b0;
      sram_web2      = ~req_we[p2_idx];
      sram_oeb2      = req_we[p2_idx];
      sram_a2        = req_addr[32'(p2_idx)*ADDR_W +: ADDR_W];
      sram_bytemask2 = req_mask[32'(p2_idx)*4 +: 4];
      sram_i2        = req_wdata[32'(p2_idx)*32 +: 32];
    end
  end

  // Record each grant for the one-cycle-later response and advance the pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= 2'd0;
      pend      <= 4'd0;
      pend_port <= 4'd0;
      pend_rd   <= 4'd0;
    end else begin
      pend <= req_ready;
      for (int i = 0; i < 4; i++) begin
        if (req_ready[i]) begin
          pend_port[i] <= p2_hit && (p2_idx == 2'(i));
          pend_rd[i]   <= ~req_we[i];
        end
      end
      if (p1_hit) rr_ptr <= (p2_hit ? p2_idx : p1_idx) + 2'd1;
    end
  end

  // Responses are masked during reset so a grant followed by reset never acknowledges
  always_comb begin
    resp_valid = pend & {4{~reset}};
    resp_rdata = 128'd0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid[i] && pend_rd[i])
        resp_rdata[i*32 +: 32] = pend_port[i] ? sram_o2 : sram_o1;
    end
  end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// tb/tb_sram_rr_arbiter.sv - directed scoreboard bench for sram_rr_arbiter
module tb_sram_rr_arbiter;
  localparam int ADDR_W = 7;

  logic                clk = 1'b0;
  logic                reset;
  logic [3:0]          req_valid;
  logic [3:0]          req_ready;
  logic [3:0]          req_we;
  logic [4*ADDR_W-1:0] req_addr;
  logic [127:0]        req_wdata;
  logic [15:0]         req_mask;
  logic [3:0]          resp_valid;
  logic [127:0]        resp_rdata;
  logic [ADDR_W-1:0]   sram_a1, sram_a2;
  logic                sram_csb1, sram_csb2, sram_web1, sram_web2, sram_oeb1, sram_oeb2;
  logic [3:0]          sram_bytemask1, sram_bytemask2;
  logic [31:0]         sram_i1, sram_i2;
  logic [31:0]         sram_o1, sram_o2;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem     [0:127];
  logic [31:0] ref_mem [0:127];

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  sram_rr_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .sram_a1(sram_a1), .sram_a2(sram_a2),
    .sram_csb1(sram_csb1), .sram_csb2(sram_csb2),
    .sram_web1(sram_web1), .sram_web2(sram_web2),
    .sram_oeb1(sram_oeb1), .sram_oeb2(sram_oeb2),
    .sram_bytemask1(sram_bytemask1), .sram_bytemask2(sram_bytemask2),
    .sram_i1(sram_i1), .sram_i2(sram_i2),
    .sram_o1(sram_o1), .sram_o2(sram_o2)
  );

  always #5 clk = ~clk;

  // Dual-port macro model: masked writes, read data valid after the access edge
  always @(posedge clk) begin
    if (!sram_csb1) begin
      if (!sram_web1) begin
        for (int b = 0; b < 4; b++)
          if (sram_bytemask1[b]) mem[sram_a1][b*8 +: 8] = sram_i1[b*8 +: 8];
      end else sram_o1 <= mem[sram_a1];
    end
    if (!sram_csb2) begin
      if (!sram_web2) begin
        for (int b = 0; b < 4; b++)
          if (sram_bytemask2[b]) mem[sram_a2][b*8 +: 8] = sram_i2[b*8 +: 8];
      end else sram_o2 <= mem[sram_a2];
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [31:0] d, input logic [3:0] m);
    req_valid[i]               = v;
    req_we[i]                  = we;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_wdata[i*32 +: 32]      = d;
    req_mask[i*4 +: 4]         = m;
  endtask

  task automatic clear_all();
    req_valid = 4'd0;
    req_we    = 4'd0;
    req_addr  = '0;
    req_wdata = 128'd0;
    req_mask  = 16'd0;
  endtask

  // One cycle: check grants/ports, queue expected responses, check responses after the edge
  task automatic step(input logic [3:0] exp_rdy, input logic [1:0] exp_csb, input bit rst_after);
    logic [3:0]        ev;
    logic [127:0]      ed;
    logic [ADDR_W-1:0] a;
    exp_t              it;
    #1;
    check("req_ready", 128'(req_ready), 128'(exp_rdy));
    check("csb", 128'({sram_csb2, sram_csb1}), 128'(exp_csb));
    for (int i = 0; i < 4; i++) begin
      if (exp_rdy[i]) begin
        a       = req_addr[i*ADDR_W +: ADDR_W];
        it.idx  = i;
        it.data = req_we[i] ? 32'd0 : ref_mem[a];
        exp_q.push_back(it);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (exp_rdy[i] && req_we[i]) begin
        a = req_addr[i*ADDR_W +: ADDR_W];
        for (int b = 0; b < 4; b++)
          if (req_mask[i*4 + b]) ref_mem[a][b*8 +: 8] = req_wdata[i*32 + b*8 +: 8];
      end
    end
    @(posedge clk);
    if (rst_after) begin
      reset = 1'b1;
      exp_q.delete();
    end
    #1;
    ev = 4'd0;
    ed = 128'd0;
    while (exp_q.size() > 0) begin
      it = exp_q.pop_front();
      ev[it.idx] = 1'b1;
      ed[it.idx*32 +: 32] = it.data;
    end
    check("resp_valid", 128'(resp_valid), 128'(ev));
    check("resp_rdata", resp_rdata, ed);
    @(negedge clk);
  endtask

  initial begin
    for (int a = 0; a < 128; a++) begin
      mem[a]     = (32'(a) * 32'h0101_0101) ^ 32'hA5A5_0000;
      ref_mem[a] = (32'(a) * 32'h0101_0101) ^ 32'hA5A5_0000;
    end
    sram_o1 = 32'd0;
    sram_o2 = 32'd0;
    reset   = 1'b1;
    clear_all();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, ADDR_W'(i), 32'd0, 4'hF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    // reset state
    check("rst_ready", 128'(req_ready), 128'd0);
    check("rst_resp_valid", 128'(resp_valid), 128'd0);
    check("rst_resp_rdata", resp_rdata, 128'd0);
    check("rst_ports_ctl", 128'({sram_csb1, sram_csb2, sram_web1, sram_web2, sram_oeb1, sram_oeb2}), 128'h3F);
    check("rst_ports_data", 128'({sram_a1, sram_a2, sram_bytemask1, sram_bytemask2, sram_i1, sram_i2}), 128'd0);
    reset = 1'b0;

    // four reads, distinct addresses, rr_ptr=0
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, ADDR_W'(10 + i), 32'd0, 4'hF);
    step(4'b0011, 2'b00, 0);
    step(4'b1100, 2'b00, 0);
    step(4'b0011, 2'b00, 0);
    clear_all();
    step(4'b0000, 2'b11, 0);

    // single write then read by requester 2
    set_req(2, 1'b1, 1'b1, 7'd5, 32'hDEAD_BEEF, 4'hF);
    step(4'b0100, 2'b10, 0);
    set_req(2, 1'b1, 1'b0, 7'd5, 32'd0, 4'hF);
    step(4'b0100, 2'b10, 0);
    check("wr_rd_data", 128'(resp_rdata[64 +: 32]), 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF);
    clear_all();

    // byte mask merge by requester 3
    set_req(3, 1'b1, 1'b1, 7'd9, 32'h1122_3344, 4'hF);
    step(4'b1000, 2'b10, 0);
    set_req(3, 1'b1, 1'b1, 7'd9, 32'hAABB_CCDD, 4'h5);
    step(4'b1000, 2'b10, 0);
    set_req(3, 1'b1, 1'b0, 7'd9, 32'd0, 4'hF);
    step(4'b1000, 2'b10, 0);
    check("mask_data", 128'(resp_rdata[96 +: 32]), 128'h11BB_33DD);
    clear_all();

    // address conflict: write by 0 and read by 1 to addr 3
    set_req(0, 1'b1, 1'b1, 7'd3, 32'hCAFE_F00D, 4'hF);
    set_req(1, 1'b1, 1'b0, 7'd3, 32'd0, 4'hF);
    step(4'b0001, 2'b10, 0);
    set_req(0, 1'b0, 1'b0, 7'd0, 32'd0, 4'h0);
    step(4'b0010, 2'b10, 0);
    check("conflict_data", 128'(resp_rdata[32 +: 32]), 128'hCAFE_F00D);
    clear_all();

    // two reads to the same address use both ports
    set_req(2, 1'b1, 1'b0, 7'd7, 32'd0, 4'hF);
    set_req(3, 1'b1, 1'b0, 7'd7, 32'd0, 4'hF);
    step(4'b1100, 2'b00, 0);
    check("same_addr_rdata", 128'(resp_rdata[96 +: 32]), 128'(resp_rdata[64 +: 32]));
    clear_all();

    // zero-mask write leaves memory untouched
    set_req(0, 1'b1, 1'b1, 7'd9, 32'hFFFF_FFFF, 4'h0);
    step(4'b0001, 2'b10, 0);
    set_req(0, 1'b1, 1'b0, 7'd9, 32'd0, 4'hF);
    step(4'b0001, 2'b10, 0);
    check("mask0_data", 128'(resp_rdata[0 +: 32]), 128'h11BB_33DD);
    clear_all();

    // reset in the cycle after a grant suppresses its response
    set_req(1, 1'b1, 1'b0, 7'd10, 32'd0, 4'hF);
    step(4'b0010, 2'b10, 1);
    step(4'b0000, 2'b11, 0);
    check("rst_mid_rdata", resp_rdata, 128'd0);
    reset = 1'b0;
    set_req(2, 1'b1, 1'b0, 7'd11, 32'd0, 4'hF);
    step(4'b0110, 2'b00, 0);
    clear_all();
    step(4'b0000, 2'b11, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
